// File: rtl/pv_tone_gen.sv
// pv_tone_gen: multi-channel square-wave tone generator with a shared prescaler,
// a small register file (periods, enable mask, control) and a summing mixer.
//
// Ports:
//   clk      - single clock, all state changes on posedge
//   nRESET   - synchronous active-low reset
//   ce       - sound clock enable; prescaler only advances when high
//   wr_en    - register write strobe (one cycle per write)
//   addr     - register address, shared by write and readback
//   wr_data  - register write data
//   rd_data  - registered readback of the register selected by addr
//   tone_o   - registered per-channel square output
//   tick_o   - one-cycle pulse following each prescaler wrap
//   audio    - registered mix: count of enabled high channels, MSB-aligned
//
// Register map: 0..NUM_CH-1 period P[i], NUM_CH enable mask,
// NUM_CH+1 control (bit0 global mute, bit1 phase sync, write-only strobe).
module pv_tone_gen #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PER_W    = 6,
  parameter int unsigned PRESCALE = 512,
  parameter int unsigned OUT_W    = 8,
  localparam int unsigned SUM_W   = $clog2(NUM_CH + 1),
  localparam int unsigned ADDR_W  = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              ce,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] tone_o,
  output logic              tick_o,
  output logic [OUT_W-1:0]  audio
);

  localparam int unsigned PS_W = $clog2(PRESCALE);

  // Register file
  logic [PER_W-1:0]  r_per [NUM_CH];
  logic [NUM_CH-1:0] r_mask;
  logic              r_mute;

  // Timing and tone state
  logic [PS_W-1:0]   r_presc;
  logic [PER_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_tone;
  logic              r_tick;
  logic [OUT_W-1:0]  r_audio;
  logic [7:0]        r_rd;

  // Decode and datapath wires
  logic [NUM_CH-1:0] w_wr_per;
  logic              w_wr_mask;
  logic              w_wr_ctrl;
  logic              w_sync;
  logic              w_tick;
  logic [PER_W-1:0]  w_lim [NUM_CH];
  logic [NUM_CH-1:0] w_act;
  logic [SUM_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_mix;
  logic [7:0]        w_rd;
  logic              w_unused;

  // Write decode; phase sync is a strobe carried by a control write
  always_comb begin
    w_wr_per = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr_per[i] = wr_en && (addr == ADDR_W'(i));
    end
    w_wr_mask = wr_en && (addr == ADDR_W'(NUM_CH));
    w_wr_ctrl = wr_en && (addr == ADDR_W'(NUM_CH + 1));
    w_sync    = w_wr_ctrl && wr_data[1];
  end

  // Prescaler terminal count
  assign w_tick = ce && (r_presc == PS_W'(PRESCALE - 1));

  // Half-period limit: all-ones minus P, which in PER_W bits is just ~P
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_lim[i] = ~r_per[i];
    end
  end

  // Mixer: count enabled high channels and left-align into OUT_W
  always_comb begin
    w_act = r_tone & r_mask;
    w_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum + SUM_W'(w_act[i]);
    end
    w_mix = OUT_W'(w_sum) << (OUT_W - SUM_W);
  end

  // Readback mux; unmapped addresses and unused bits read as zero
  always_comb begin
    w_rd = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(i)) begin
        w_rd = 8'(r_per[i]);
      end
    end
    if (addr == ADDR_W'(NUM_CH)) begin
      w_rd = 8'(r_mask);
    end
    if (addr == ADDR_W'(NUM_CH + 1)) begin
      w_rd = {7'b0, r_mute};
    end
  end

  // High write-data bits are not stored by any register
  assign w_unused = &{1'b0, wr_data};

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_per[i] <= '1;
        r_cnt[i] <= '0;
      end
      r_mask  <= '1;
      r_mute  <= 1'b0;
      r_presc <= '0;
      r_tone  <= '0;
      r_tick  <= 1'b0;
      r_audio <= '0;
      r_rd    <= '0;
    end else begin
      // Register writes
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_wr_per[i]) begin
          r_per[i] <= wr_data[PER_W-1:0];
        end
      end
      if (w_wr_mask) begin
        r_mask <= wr_data[NUM_CH-1:0];
      end
      if (w_wr_ctrl) begin
        r_mute <= wr_data[0];
      end

      // Prescaler; sync wins over a coincident wrap
      if (w_sync) begin
        r_presc <= '0;
      end else if (ce) begin
        r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      end
      r_tick <= w_tick && !w_sync;

      // Channel counters use the pre-write limit; >= lets a shortened
      // period toggle on the next tick instead of waiting for wrap-around
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_sync || (w_lim[i] == '0)) begin
          r_cnt[i]  <= '0;
          r_tone[i] <= 1'b0;
        end else if (w_tick) begin
          if (r_cnt[i] >= (w_lim[i] - PER_W'(1))) begin
            r_cnt[i]  <= '0;
            r_tone[i] <= ~r_tone[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + PER_W'(1);
          end
        end
      end

      // Mute gates only the output; counters keep running
      r_audio <= r_mute ? '0 : w_mix;
      r_rd    <= w_rd;
    end
  end

  assign rd_data = r_rd;
  assign tone_o  = r_tone;
  assign tick_o  = r_tick;
  assign audio   = r_audio;

endmodule

// File: tb/tb_pv_tone_gen.sv
// Testbench for pv_tone_gen (NUM_CH=3, PER_W=6, PRESCALE=4, OUT_W=8).
module tb_pv_tone_gen;

  logic       clk = 1'b0;
  logic       nRESET;
  logic       ce;
  logic       wr_en;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [2:0] tone_o;
  logic       tick_o;
  logic [7:0] audio;

  always #5 clk = ~clk;

  pv_tone_gen #(
    .NUM_CH(3), .PER_W(6), .PRESCALE(4), .OUT_W(8)
  ) dut (
    .clk(clk), .nRESET(nRESET), .ce(ce), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .tone_o(tone_o), .tick_o(tick_o),
    .audio(audio)
  );

  localparam int K_TONE = 0;
  localparam int K_TICK = 1;
  localparam int K_AUD  = 2;
  localparam int K_RD   = 3;

  typedef struct {
    string      name;
    int         kind;
    int         due;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  exp_t sb[$];
  vec_t vt[20];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_TONE:  return {5'b0, tone_o};
      K_TICK:  return {7'b0, tick_o};
      K_AUD:   return audio;
      default: return rd_data;
    endcase
  endfunction

  // Scoreboard: compare every expectation due in this cycle
  always @(negedge clk) begin
    int i;
    logic [7:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = observe(sb[i].kind);
        n_cmp++;
        if (sb[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: not sampled at cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %02h, expected %02h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input string name, input int kind, input int due, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.due  = due;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Advance until tick_o is seen; a timeout becomes a failing expectation
  task automatic wait_tick(output int c);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      step();
      if (tick_o === 1'b1) found = 1'b1;
    end
    c = cyc;
    if (!found) expect_at("tick_wait", K_TICK, cyc, 8'h01);
  endtask

  initial begin
    int c;
    int d;

    // Register table: expected rd_data is the pre-write value at addr
    vt[0]  = '{1'b0, 3'd0, 8'h00, 8'h3F};
    vt[1]  = '{1'b0, 3'd3, 8'h00, 8'h07};
    vt[2]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    vt[3]  = '{1'b1, 3'd0, 8'hFF, 8'h3F};
    vt[4]  = '{1'b0, 3'd0, 8'h00, 8'h3F};
    vt[5]  = '{1'b1, 3'd1, 8'h55, 8'h3F};
    vt[6]  = '{1'b0, 3'd1, 8'h00, 8'h15};
    vt[7]  = '{1'b1, 3'd3, 8'hFA, 8'h07};
    vt[8]  = '{1'b0, 3'd3, 8'h00, 8'h02};
    vt[9]  = '{1'b1, 3'd4, 8'h03, 8'h00};
    vt[10] = '{1'b0, 3'd4, 8'h00, 8'h01};
    vt[11] = '{1'b1, 3'd5, 8'h12, 8'h00};
    vt[12] = '{1'b0, 3'd5, 8'h00, 8'h00};
    vt[13] = '{1'b1, 3'd7, 8'hAA, 8'h00};
    vt[14] = '{1'b0, 3'd2, 8'h00, 8'h3F};
    vt[15] = '{1'b1, 3'd4, 8'h00, 8'h01};
    vt[16] = '{1'b0, 3'd4, 8'h00, 8'h00};
    vt[17] = '{1'b1, 3'd3, 8'h07, 8'h02};
    vt[18] = '{1'b1, 3'd1, 8'h3F, 8'h15};
    vt[19] = '{1'b0, 3'd1, 8'h00, 8'h3F};

    nRESET = 1'b0; ce = 1'b0; wr_en = 1'b0; addr = 3'd0; wr_data = 8'h00;
    repeat (3) step();
    expect_at("rst.tone", K_TONE, cyc, 8'h00);
    expect_at("rst.tick", K_TICK, cyc, 8'h00);
    expect_at("rst.audio", K_AUD, cyc, 8'h00);
    expect_at("rst.rd", K_RD, cyc, 8'h00);
    nRESET = 1'b1;

    for (int r = 0; r < 20; r++) begin
      wr_en   = vt[r].wr;
      addr    = vt[r].addr;
      wr_data = vt[r].data;
      expect_at($sformatf("tbl[%0d].rd", r), K_RD, cyc + 1, vt[r].exp_rd);
      step();
    end
    wr_en = 1'b0;
    expect_at("tbl.tone", K_TONE, cyc, 8'h00);

    // Single channel, L=2: toggle every 2 ticks, audio one cycle later
    wr(3'd0, 8'h3D);
    ce = 1'b1;
    wait_tick(c);
    expect_at("A.tone0", K_TONE, c, 8'h00);
    expect_at("A.tick0", K_TICK, c, 8'h01);
    for (int k = 1; k < 4; k++) expect_at("A.tick_lo", K_TICK, c + k, 8'h00);
    expect_at("A.tick4", K_TICK, c + 4, 8'h01);
    expect_at("A.tone4", K_TONE, c + 4, 8'h01);
    expect_at("A.aud4", K_AUD, c + 4, 8'h00);
    expect_at("A.aud5", K_AUD, c + 5, 8'h40);
    expect_at("A.tone8", K_TONE, c + 8, 8'h01);
    expect_at("A.tick8", K_TICK, c + 8, 8'h01);
    expect_at("A.aud9", K_AUD, c + 9, 8'h40);
    expect_at("A.tone12", K_TONE, c + 12, 8'h00);
    expect_at("A.aud13", K_AUD, c + 13, 8'h00);
    goto_cyc(c + 13);

    // All channels L=1: toggle every tick
    ce = 1'b0;
    wr(3'd0, 8'h3E); wr(3'd1, 8'h3E); wr(3'd2, 8'h3E);
    wr(3'd3, 8'h07); wr(3'd4, 8'h02);
    ce = 1'b1;
    wait_tick(c);
    expect_at("B.tone0", K_TONE, c, 8'h07);
    expect_at("B.aud0", K_AUD, c, 8'h00);
    expect_at("B.aud1", K_AUD, c + 1, 8'hC0);
    expect_at("B.tone4", K_TONE, c + 4, 8'h00);
    expect_at("B.aud5", K_AUD, c + 5, 8'h00);
    expect_at("B.tone8", K_TONE, c + 8, 8'h07);
    expect_at("B.aud9", K_AUD, c + 9, 8'hC0);
    goto_cyc(c + 9);

    // Channel 1 at L=20, shortened to L=3 once its count is 10
    ce = 1'b0;
    wr(3'd0, 8'h3F); wr(3'd2, 8'h3F); wr(3'd1, 8'h2B); wr(3'd4, 8'h02);
    ce = 1'b1;
    wait_tick(c);
    expect_at("C.tone0", K_TONE, c, 8'h00);
    expect_at("C.tone36", K_TONE, c + 36, 8'h00);
    expect_at("C.tone39", K_TONE, c + 39, 8'h00);
    expect_at("C.tone40", K_TONE, c + 40, 8'h02);
    expect_at("C.aud41", K_AUD, c + 41, 8'h40);
    expect_at("C.tone48", K_TONE, c + 48, 8'h02);
    expect_at("C.tone52", K_TONE, c + 52, 8'h00);
    expect_at("C.tone64", K_TONE, c + 64, 8'h02);
    // Silencing, masking and mute
    expect_at("D.tone68", K_TONE, c + 68, 8'h06);
    expect_at("D.tone71", K_TONE, c + 71, 8'h02);
    expect_at("D.tone72", K_TONE, c + 72, 8'h02);
    expect_at("D.tone76", K_TONE, c + 76, 8'h01);
    expect_at("D.aud77", K_AUD, c + 77, 8'h00);
    expect_at("D.tone80", K_TONE, c + 80, 8'h00);
    expect_at("D.tone84", K_TONE, c + 84, 8'h01);
    expect_at("D.aud85", K_AUD, c + 85, 8'h00);
    expect_at("D.tone88", K_TONE, c + 88, 8'h02);
    expect_at("D.aud89", K_AUD, c + 89, 8'h40);
    expect_at("D.tone92", K_TONE, c + 92, 8'h03);
    expect_at("D.aud92", K_AUD, c + 92, 8'h00);
    expect_at("D.aud93", K_AUD, c + 93, 8'h00);
    expect_at("D.tone96", K_TONE, c + 96, 8'h02);
    expect_at("D.aud97", K_AUD, c + 97, 8'h00);
    expect_at("D.tone100", K_TONE, c + 100, 8'h01);
    // Phase sync coincident with a tick
    expect_at("E.tone104", K_TONE, c + 104, 8'h00);
    expect_at("E.rd105", K_RD, c + 105, 8'h00);
    expect_at("E.aud105", K_AUD, c + 105, 8'h00);
    expect_at("E.tick108", K_TICK, c + 108, 8'h01);
    expect_at("E.tone108", K_TONE, c + 108, 8'h01);
    expect_at("E.tone112", K_TONE, c + 112, 8'h00);
    expect_at("E.tone116", K_TONE, c + 116, 8'h03);
    expect_at("E.aud117", K_AUD, c + 117, 8'h40);
    // Mid-run reset, readback, idle with ce=0
    expect_at("F.tone", K_TONE, c + 118, 8'h00);
    expect_at("F.tick", K_TICK, c + 118, 8'h00);
    expect_at("F.aud", K_AUD, c + 118, 8'h00);
    expect_at("F.rd", K_RD, c + 118, 8'h00);
    expect_at("F.rd_p0", K_RD, c + 119, 8'h3F);
    expect_at("F.rd_mask", K_RD, c + 120, 8'h07);
    expect_at("F.rd_unmapped", K_RD, c + 121, 8'h00);
    for (int k = 122; k < 142; k++) begin
      expect_at("F.idle_tick", K_TICK, c + k, 8'h00);
      expect_at("F.idle_tone", K_TONE, c + k, 8'h00);
    end

    goto_cyc(c + 37);  wr(3'd1, 8'h3C);
    goto_cyc(c + 65);  wr(3'd2, 8'h3E);
    goto_cyc(c + 69);  wr(3'd2, 8'h3F);
    goto_cyc(c + 73);  wr(3'd3, 8'h02); wr(3'd0, 8'h3E);
    goto_cyc(c + 90);  wr(3'd4, 8'h01);
    goto_cyc(c + 103); wr(3'd4, 8'h02);
    addr = 3'd4;
    goto_cyc(c + 117);
    nRESET = 1'b0; ce = 1'b0;
    step();
    nRESET = 1'b1; addr = 3'd0;
    step();
    addr = 3'd3;
    step();
    addr = 3'd5;
    goto_cyc(c + 141);

    // First toggle after reset release comes a full period after the first tick
    wr(3'd0, 8'h3D);
    ce = 1'b1;
    wait_tick(d);
    expect_at("G.tone0", K_TONE, d, 8'h00);
    expect_at("G.tick4", K_TICK, d + 4, 8'h01);
    expect_at("G.tone4", K_TONE, d + 4, 8'h01);
    goto_cyc(d + 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pv_tone_gen.md
PV_TONE_GEN -- requirements
Module: pv_tone_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of square-wave tone channels (1..8).
REQ-002 SHALL have parameter PER_W, default 6, period register width in bits (1..8).
REQ-003 SHALL have parameter PRESCALE, default 512, number of ce pulses per channel tick (>=2).
REQ-004 SHALL have parameter OUT_W, default 8, mixed audio width; OUT_W >= SUM_W, where SUM_W = clog2(NUM_CH+1).
REQ-005 SHALL have derived ADDR_W = clog2(NUM_CH+2), register address width.
REQ-006 SHALL have port clk  in  1  single clock; all logic rises on posedge clk.
REQ-007 SHALL have port nRESET  in  1  reset; synchronous and active-low.
REQ-008 SHALL have port ce  in  1  sound clock enable; the prescaler advances only when ce=1.
REQ-009 SHALL have port wr_en  in  1  register write strobe, one cycle per write.
REQ-010 SHALL have port addr  in  ADDR_W  register address shared by write and read.
REQ-011 SHALL have port wr_data  in  8  register write data.
REQ-012 SHALL have port rd_data  out  8  registered readback of the register at addr.
REQ-013 SHALL have port tone_o  out  NUM_CH  registered per-channel square output.
REQ-014 SHALL have port tick_o  out  1  one-cycle pulse on each prescaler terminal count.
REQ-015 SHALL have port audio  out  OUT_W  registered mixed output.

Function
REQ-016 Register map SHALL be: addr 0..NUM_CH-1 = period P[i] (low PER_W bits stored); NUM_CH = enable mask (low NUM_CH bits); NUM_CH+1 = control (bit0 global mute, bit1 phase sync).
REQ-017 Writes SHALL take effect on the clock edge where wr_en=1; writes to unmapped addresses SHALL be ignored.
REQ-018 rd_data SHALL present the register at addr one cycle after addr is applied; unused bits, unmapped addresses and control bit1 SHALL read 0.
REQ-019 Prescaler SHALL count ce pulses 0..PRESCALE-1, wrap to 0, and assert tick_o for the single cycle in which it wraps.
REQ-020 Channel limit SHALL be L[i] = (2^PER_W-1) - P[i], computed in PER_W bits.
REQ-021 On tick with L[i]>0: if counter[i] >= L[i]-1, counter[i] SHALL be cleared to 0 and tone_o[i] toggled; otherwise counter[i] SHALL increment by 1. Half-period is therefore L[i] ticks.
REQ-022 The >= comparison SHALL ensure that a period write lowering L below the current count toggles on the next tick, with no wrap-around wait.
REQ-023 L[i]=0 SHALL silence channel i: tone_o[i] forced 0 and counter[i] held at 0.
REQ-024 If a write and a tick occur in the same cycle, the tick SHALL use the pre-write register value.
REQ-025 Writing control with bit1=1 SHALL clear the prescaler, all counters and all tone_o on that edge, override any coincident tick, and leave bit1 reading 0.
REQ-026 sum SHALL be the count of i where tone_o[i]=1 and mask[i]=1, in SUM_W bits.
REQ-027 audio SHALL equal {sum, (OUT_W-SUM_W) zeros}, registered one cycle after tone_o/mask change; global mute SHALL force audio=0 without stopping the counters.

Reset
REQ-028 While nRESET=0 at a clock edge: P[i] all ones (silent), mask all ones, control 0, prescaler 0, counters 0, tone_o 0, tick_o 0, audio 0, rd_data 0.
REQ-029 A reset asserted mid-period SHALL abandon the current phase; the first toggle after release SHALL occur a full L[i] ticks after the first tick.

Verification
REQ-030 PRESCALE=4, ce=1 constantly, write P[0]=0x3D (L=2) -> tick_o every 4 cycles; tone_o[0] toggles every 2 ticks (8 cycles); audio toggles 0x00/0x40 one cycle later.
REQ-031 All three channels P=0x3E (L=1), mask=7 -> tone_o toggles every tick; audio alternates 0x00 and 0xC0.
REQ-032 Channel 1 counting with L=20 at count 10; write P[1]=0x3C (L=3) -> toggles on the next tick, then every 3 ticks.
REQ-033 Write P[2]=0x3F -> tone_o[2]=0 and stays 0; write mask=0x2 -> only channel 1 contributes; write control=0x01 -> audio=0 while tone_o keeps toggling.
REQ-034 Write control=0x02 coincident with tick_o -> prescaler, counters and tone_o all 0 next cycle; readback of addr NUM_CH+1 = 0x00.
REQ-035 Drop nRESET for one edge mid-run -> all outputs 0, readback of P[0] = 0x3F and mask = 0x07; ce=0 held -> no tick_o and no toggles.
